// File: rtl/mm_pkg.sv
// Shared types and defaults for the matrix-multiply sequencer and its MAC datapath.
package mm_pkg;

  localparam int unsigned DIM_W_DEF = 16;
  localparam int unsigned CYC_W_DEF = 32;

  // Sequencer states
  typedef logic [1:0] seq_state_t;
  localparam seq_state_t S_IDLE  = 2'd0;
  localparam seq_state_t S_ISSUE = 2'd1;
  localparam seq_state_t S_DRAIN = 2'd2;

  // One MAC operation as seen by the datapath
  typedef struct packed {
    logic [DIM_W_DEF-1:0] i;
    logic [DIM_W_DEF-1:0] j;
    logic [DIM_W_DEF-1:0] k;
    logic                 first;
    logic                 last;
  } mm_op_t;

endpackage

// File: rtl/mm_idx_counter.sv
// Three-level nested wrap counter walking i (outer), j (middle), k (inner).
module mm_idx_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] lim_m,
  input  logic [W-1:0] lim_k,
  input  logic [W-1:0] lim_n,
  output logic [W-1:0] idx_i,
  output logic [W-1:0] idx_j,
  output logic [W-1:0] idx_k,
  output logic         first,
  output logic         last,
  output logic         last_all
);

  logic k_wrap;
  logic j_wrap;
  logic i_wrap;
  logic [W-1:0] k_inc;

  // Wrap points; limits are non-zero whenever en is asserted
  always_comb begin
    k_inc    = idx_k + W'(1);
    k_wrap   = (idx_k == lim_k - W'(1));
    j_wrap   = (idx_j == lim_n - W'(1));
    i_wrap   = (idx_i == lim_m - W'(1));
    last_all = k_wrap && j_wrap && i_wrap;
  end

  // Index registers; first/last are registered alongside k so they stay glitch-free
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_i <= '0;
      idx_j <= '0;
      idx_k <= '0;
      first <= 1'b0;
      last  <= 1'b0;
    end else if (clr) begin
      idx_i <= '0;
      idx_j <= '0;
      idx_k <= '0;
      first <= 1'b1;
      last  <= (lim_k == W'(1));
    end else if (en) begin
      if (k_wrap) begin
        idx_k <= '0;
        first <= 1'b1;
        last  <= (lim_k == W'(1));
        if (j_wrap) begin
          idx_j <= '0;
          idx_i <= i_wrap ? '0 : idx_i + W'(1);
        end else begin
          idx_j <= idx_j + W'(1);
        end
      end else begin
        idx_k <= k_inc;
        first <= 1'b0;
        last  <= (k_inc == lim_k - W'(1));
      end
    end
  end

endmodule

// File: rtl/mm_seq_ctrl.sv
// Matrix-multiply sequencer: issues M*N*K MAC ops, counts results, reports status.
module mm_seq_ctrl
  import mm_pkg::*;
#(
  parameter int unsigned DIM_W = DIM_W_DEF,
  parameter int unsigned CYC_W = CYC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [DIM_W-1:0] cfg_m,
  input  logic [DIM_W-1:0] cfg_k,
  input  logic [DIM_W-1:0] cfg_n,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [DIM_W-1:0] op_i,
  output logic [DIM_W-1:0] op_j,
  output logic [DIM_W-1:0] op_k,
  output logic             op_first,
  output logic             op_last,
  input  logic             res_valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CYC_W-1:0] cycle_cnt
);

  localparam int unsigned RC_W = 2 * DIM_W;

  seq_state_t       state_q, state_d;
  logic [DIM_W-1:0] m_q, k_q, n_q;
  logic [RC_W-1:0]  mn_q;
  logic [RC_W-1:0]  res_cnt_q;
  logic             op_valid_d, busy_d, done_d, err_d;
  logic             load_cfg, clr_stats, cnt_en, cyc_en, res_en;
  logic             dim_zero;
  logic             last_all;
  logic [DIM_W-1:0] lim_k;

  assign dim_zero = (cfg_m == '0) || (cfg_k == '0) || (cfg_n == '0);
  // Counter preloads first/last on the start edge, before the shadow K is visible
  assign lim_k    = load_cfg ? cfg_k : k_q;

  mm_idx_counter #(.W(DIM_W)) u_idx (
    .clk      (clk),
    .rst      (rst),
    .clr      (load_cfg),
    .en       (cnt_en),
    .lim_m    (m_q),
    .lim_k    (lim_k),
    .lim_n    (n_q),
    .idx_i    (op_i),
    .idx_j    (op_j),
    .idx_k    (op_k),
    .first    (op_first),
    .last     (op_last),
    .last_all (last_all)
  );

  // Next-state and control decode; abort while busy overrides everything
  always_comb begin
    state_d    = state_q;
    op_valid_d = op_valid;
    busy_d     = busy;
    done_d     = done;
    err_d      = err;
    load_cfg   = 1'b0;
    clr_stats  = 1'b0;
    cnt_en     = 1'b0;
    cyc_en     = 1'b0;
    res_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          load_cfg  = 1'b1;
          clr_stats = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
          if (dim_zero) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d    = S_ISSUE;
            op_valid_d = 1'b1;
            busy_d     = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        cyc_en = 1'b1;
        res_en = 1'b1;
        if (op_valid && op_ready) begin
          cnt_en = 1'b1;
          if (last_all) begin
            state_d    = S_DRAIN;
            op_valid_d = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        cyc_en = 1'b1;
        res_en = 1'b1;
        if (res_cnt_q == mn_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d    = S_IDLE;
        op_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      op_valid_d = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      cnt_en     = 1'b0;
      cyc_en     = 1'b0;
      res_en     = 1'b0;
    end
  end

  // State and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_valid <= op_valid_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
    end
  end

  // Shadow config, latched once per accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q  <= '0;
      k_q  <= '0;
      n_q  <= '0;
      mn_q <= '0;
    end else if (load_cfg) begin
      m_q  <= cfg_m;
      k_q  <= cfg_k;
      n_q  <= cfg_n;
      mn_q <= RC_W'(cfg_m) * RC_W'(cfg_n);
    end
  end

  // Result counter (saturates at M*N) and saturating cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      res_cnt_q <= '0;
      cycle_cnt <= '0;
    end else if (clr_stats) begin
      res_cnt_q <= '0;
      cycle_cnt <= '0;
    end else begin
      if (res_en && res_valid && (res_cnt_q != mn_q)) begin
        res_cnt_q <= res_cnt_q + RC_W'(1);
      end
      if (cyc_en && (cycle_cnt != '1)) begin
        cycle_cnt <= cycle_cnt + CYC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mm_seq_ctrl.sv
// Directed bench for mm_seq_ctrl with an in-bench op-order model and a 2-cycle datapath model.
module tb_mm_seq_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [DW-1:0] cfg_m, cfg_k, cfg_n;
  logic          op_valid;
  logic          op_ready;
  logic [DW-1:0] op_i, op_j, op_k;
  logic          op_first, op_last;
  logic          res_valid;
  logic          busy, done, err;
  logic [CW-1:0] cycle_cnt;

  int checks = 0;
  int errors = 0;

  // Bench-side models
  int          ready_mode;
  int          rdy_ctr;
  logic [1:0]  res_pipe;
  int          op_cnt;
  int          ek, en;
  int          ei, ej, ekk;
  logic        stalled;
  logic [63:0] held;

  mm_seq_ctrl #(.DIM_W(DW), .CYC_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .cfg_m     (cfg_m),
    .cfg_k     (cfg_k),
    .cfg_n     (cfg_n),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_i      (op_i),
    .op_j      (op_j),
    .op_k      (op_k),
    .op_first  (op_first),
    .op_last   (op_last),
    .res_valid (res_valid),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive ready/res_valid, score any handshake, then advance past the edge
  task automatic step();
    logic        hs;
    logic        exp_last;
    logic [63:0] cur;
    cur = 64'({op_i, op_j, op_k, op_first, op_last});
    if (stalled && op_valid) check_eq("stall_hold", cur, held);
    op_ready  = (ready_mode == 0) ? 1'b1 : (rdy_ctr % 3 == 0);
    rdy_ctr++;
    res_valid = res_pipe[1];
    hs        = op_valid && op_ready && !abort;
    exp_last  = (ekk == ek - 1);
    if (hs) begin
      check_eq("op_seq", cur, 64'({DW'(ei), DW'(ej), DW'(ekk), (ekk == 0), exp_last}));
      op_cnt++;
      ekk++;
      if (ekk == ek) begin
        ekk = 0;
        ej++;
        if (ej == en) begin
          ej = 0;
          ei++;
        end
      end
    end
    res_pipe = {res_pipe[0], hs && exp_last};
    stalled  = op_valid && !op_ready && !abort;
    held     = cur;
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int m, input int k, input int n);
    cfg_m  = DW'(m);
    cfg_k  = DW'(k);
    cfg_n  = DW'(n);
    ek     = k;
    en     = n;
    ei     = 0;
    ej     = 0;
    ekk    = 0;
    op_cnt = 0;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    check_eq({tag, "_done"}, 64'(done), 64'(1));
  endtask

  initial begin
    int seen_bad;
    int guard;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_m = '0; cfg_k = '0; cfg_n = '0;
    op_ready = 1'b0; res_valid = 1'b0; res_pipe = '0;
    ready_mode = 0; rdy_ctr = 0; op_cnt = 0;
    ek = 0; en = 0; ei = 0; ej = 0; ekk = 0;
    stalled = 1'b0; held = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    check_eq("rst_op_valid", 64'(op_valid), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_done", 64'(done), 64'(0));
    check_eq("rst_err", 64'(err), 64'(0));
    check_eq("rst_cycle", 64'(cycle_cnt), 64'(0));
    check_eq("rst_idx", 64'({op_i, op_j, op_k}), 64'(0));
    rst = 1'b0;
    step();

    // 2x3x2, ready always high
    start_job(2, 3, 2);
    wait_done("t1", 40);
    check_eq("t1_ops", 64'(op_cnt), 64'(12));
    check_eq("t1_busy", 64'(busy), 64'(0));
    check_eq("t1_err", 64'(err), 64'(0));
    check_eq("t1_cycle", 64'(cycle_cnt), 64'(15));
    check_eq("t1_op_valid", 64'(op_valid), 64'(0));

    // Same job with ready high one cycle in three
    ready_mode = 1;
    rdy_ctr    = 0;
    start_job(2, 3, 2);
    wait_done("t2", 100);
    check_eq("t2_ops", 64'(op_cnt), 64'(12));
    ready_mode = 0;

    // Zero inner dimension
    start_job(2, 0, 2);
    check_eq("t3_err", 64'(err), 64'(1));
    check_eq("t3_done", 64'(done), 64'(1));
    check_eq("t3_busy", 64'(busy), 64'(0));
    check_eq("t3_op_valid", 64'(op_valid), 64'(0));
    seen_bad = 0;
    repeat (5) begin
      step();
      if (busy || op_valid) seen_bad++;
    end
    check_eq("t3_quiet", 64'(seen_bad), 64'(0));
    check_eq("t3_ops", 64'(op_cnt), 64'(0));

    // 4x4x4 aborted after 10 ops, then rerun
    start_job(4, 4, 4);
    check_eq("t4_err_clr", 64'(err), 64'(0));
    check_eq("t4_done_clr", 64'(done), 64'(0));
    check_eq("t4_busy", 64'(busy), 64'(1));
    guard = 0;
    while (op_cnt < 10 && guard < 200) begin
      step();
      guard++;
    end
    check_eq("t4_ops_pre", 64'(op_cnt), 64'(10));
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("t4_ab_op_valid", 64'(op_valid), 64'(0));
    check_eq("t4_ab_busy", 64'(busy), 64'(0));
    check_eq("t4_ab_done", 64'(done), 64'(0));
    check_eq("t4_ab_err", 64'(err), 64'(0));
    check_eq("t4_ab_cycle", 64'(cycle_cnt), 64'(10));
    step();
    check_eq("t4_ab_idle", 64'({busy, op_valid}), 64'(0));
    start_job(4, 4, 4);
    wait_done("t4b", 200);
    check_eq("t4b_ops", 64'(op_cnt), 64'(64));
    check_eq("t4b_cycle", 64'(cycle_cnt), 64'(67));

    // Start pulse and cfg_m change while running
    start_job(2, 3, 2);
    repeat (3) step();
    start = 1'b1;
    cfg_m = DW'(5);
    step();
    start = 1'b0;
    step();
    cfg_m = DW'(7);
    wait_done("t5", 60);
    check_eq("t5_ops", 64'(op_cnt), 64'(12));
    check_eq("t5_cycle", 64'(cycle_cnt), 64'(15));
    check_eq("t5_err", 64'(err), 64'(0));

    // 1x1x1, result two cycles after the op
    start_job(1, 1, 1);
    wait_done("t6", 20);
    check_eq("t6_ops", 64'(op_cnt), 64'(1));
    check_eq("t6_cycle", 64'(cycle_cnt), 64'(4));

    // Abort and start together in IDLE: start dropped
    cfg_m = DW'(1); cfg_k = DW'(1); cfg_n = DW'(1);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    step();
    check_eq("t7_busy", 64'(busy), 64'(0));
    check_eq("t7_done", 64'(done), 64'(1));
    check_eq("t7_op_valid", 64'(op_valid), 64'(0));
    check_eq("t7_cycle", 64'(cycle_cnt), 64'(4));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
